// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the two-requester DDR port arbiter: sequencer states,
// AXI response codes and burst length.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [7:0] AXLEN_SINGLE = 8'd0;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_arb2.sv
// Purpose: two-way round-robin pick; a tie goes to whoever did not win last.
// Latency: combinational, no state.
// Backpressure: en low suppresses any grant.
module rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = en & (|req);
    gnt_idx = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Purpose: share one single-beat AXI DDR port between two level req/done requesters.
// Latency: grant to done 4 cycles with a zero-wait slave, one idle cycle between jobs.
// Backpressure: AXI valids hold until handshake; a stalled slave stalls indefinitely.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int NREQ   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ddr_ready,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  input  logic [NREQ*DATA_W/8-1:0] wstrb,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } txn_t;

  arb_state_t state;
  txn_t       txn_q;
  txn_t       sel;
  logic       g_q;
  logic       last_grant;
  logic       gnt_vld;
  logic       gnt_idx;
  logic       aw_ok;
  logic       w_ok;

  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .en         (ddr_ready && state == ST_IDLE),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    if (gnt_idx) begin
      sel.we    = we[1];
      sel.addr  = addr[ADDR_W +: ADDR_W];
      sel.wdata = wdata[DATA_W +: DATA_W];
      sel.wstrb = wstrb[STRB_W +: STRB_W];
    end else begin
      sel.we    = we[0];
      sel.addr  = addr[0 +: ADDR_W];
      sel.wdata = wdata[0 +: DATA_W];
      sel.wstrb = wstrb[0 +: STRB_W];
    end
  end

  // AW and W retire independently; a dropped valid means that channel is finished.
  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid || wready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      txn_q      <= '0;
      g_q        <= 1'b0;
      last_grant <= 1'b1;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            txn_q      <= sel;
            g_q        <= gnt_idx;
            last_grant <= gnt_idx;
            if (sel.we) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= ST_WR;
            end else begin
              arvalid <= 1'b1;
              state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            err        <= resp_is_err(bresp);
            done[g_q]  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            rdata     <= m_rdata;
            err       <= resp_is_err(rresp);
            rready    <= 1'b0;
            done[g_q] <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign awaddr  = txn_q.addr;
  assign araddr  = txn_q.addr;
  assign m_wdata = txn_q.wdata;
  assign m_wstrb = txn_q.wstrb;
  assign awlen   = AXLEN_SINGLE;
  assign arlen   = AXLEN_SINGLE;

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
Shares the single-beat AXI-style DDR controller port (AW/W/B, AR/R) between two requesters, e.g. CPU bridge and display/DMA engine. Each requester uses a simple level req/done interface. The arbiter grants round-robin, sequences one transaction at a time, and converts it to AXI channel handshakes. No transaction is issued until the controller reports ddr_ready.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 128, data beat width; strobe width is DATA_W/8
NREQ, 2, number of requesters; fixed at 2, round-robin logic assumes 2

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
ddr_ready  in  1  DDR controller calibrated and ready
req  in  NREQ  per-requester request level, held until done
we  in  NREQ  1=write, 0=read; stable while req high
addr  in  NREQ*ADDR_W  packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NREQ*DATA_W  packed write data
wstrb  in  NREQ*DATA_W/8  packed write strobes
done  out  NREQ  one-cycle completion pulse to the served requester
err  out  1  valid with done; 1 if bresp/rresp != 0
rdata  out  DATA_W  read data, valid with done for reads, held until next read completes
awaddr  out  ADDR_W  ;  awlen  out  8  constant 0 ;  awvalid  out  1 ;  awready  in  1
m_wdata  out  DATA_W ;  m_wstrb  out  DATA_W/8 ;  wvalid  out  1 ;  wready  in  1
bresp  in  2 ;  bvalid  in  1 ;  bready  out  1
araddr  out  ADDR_W ;  arlen  out  8  constant 0 ;  arvalid  out  1 ;  arready  in  1
m_rdata  in  DATA_W ;  rresp  in  2 ;  rvalid  in  1 ;  rready  out  1

Behaviour:
- Reset: state IDLE, all valids/readies 0, done 0, err 0, rdata 0, last_grant=1 (requester 0 wins first tie).
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: when ddr_ready=1 and any req: grant g = only requester, or if both request, the one != last_grant. Latch g, we, addr, wdata, wstrb into internal regs; last_grant<=g. Next state WR (awvalid=wvalid=1) or RD_ADDR (arvalid=1). ddr_ready=0 -> stay IDLE, no grant.
- Bus outputs driven only from latched regs; requester input changes after grant are ignored.
- WR: awvalid drops the cycle after awvalid&awready; wvalid drops independently after wvalid&wready. Both handshakes in same cycle allowed. When both complete -> WR_RESP, bready=1.
- WR_RESP: on bvalid: bready<=0, err<=|bresp, -> DONE.
- RD_ADDR: on arvalid&arready: arvalid<=0, rready<=1, -> RD_DATA.
- RD_DATA: on rvalid: rdata<=m_rdata, err<=|rresp, rready<=0, -> DONE.
- DONE: done[g]=1 for exactly this cycle, then IDLE. Requester samples done and drops (or re-presents) req from next cycle; IDLE re-arbitrates that cycle.
- Minimum latency grant-to-done with zero-wait slave: write 4 cycles, read 4 cycles; one idle cycle between transactions.
- Valid signals never deassert before their handshake (AXI stability).
- Requester dropping req mid-transaction: transaction completes, done still pulses.
- ddr_ready falling mid-transaction: ignored; only gates new grants.
- Reset mid-transaction: immediate return to reset values, no done.
- No timeout; stalled slave holds state indefinitely.

Decomposition:
- Shared package ddr_arb_pkg: state encoding, AXI resp codes (OKAY=2'b00), AXLEN_SINGLE=8'd0.
- One sub-module natural: rr_arb2 (2-input round-robin grant from req, last_grant, enable).

Test Plan:
- ddr_ready=0, req=2'b01 write -> no awvalid for 20 cycles; raise ddr_ready -> awvalid=wvalid=1 at awaddr=0x0000F000, m_wdata=0x...12345678_87654321, m_wstrb=0xFFFF; done[0] after bvalid.
- Write then read same address 0x0000F000 from requester 0, slave returns stored data -> rdata=0x12345678_87654321, err=0.
- Both req high continuously, alternating writes -> grants 0,1,0,1; done alternates, none starved.
- Slave delays awready 3 cycles and wready 0 cycles -> wvalid drops after 1 cycle, awvalid held 3 cycles, single bready phase.
- rresp=2'b10 on read from requester 1 -> done[1] with err=1, rdata updated.
- rstn low while in RD_DATA -> all valids/readies 0 next cycle, no done pulse, next grant to requester 0.
